// File: rtl/shiftreg_pkg.sv
// Shared definitions for the universal shift register.
//   - Mode encodings for shift/rotate left/right.
//   - Burst-engine state encoding.
package shiftreg_pkg;

    localparam logic [1:0] MODE_SHL = 2'b00;
    localparam logic [1:0] MODE_SHR = 2'b01;
    localparam logic [1:0] MODE_ROL = 2'b10;
    localparam logic [1:0] MODE_ROR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

endpackage

// File: rtl/shiftreg_core.sv
// Combinational shift/rotate datapath.
//   d_i       current register contents
//   mode_i    operation (shift/rotate, left/right)
//   ser_in_i  serial input bit, used by the shift modes only
//   d_next_o  register value after one operation
//   ser_out_o serial output: MSB for left modes, LSB for right modes
module shiftreg_core
    import shiftreg_pkg::*;
#(
    parameter int unsigned SIZE = 8
) (
    input  logic [SIZE-1:0] d_i,
    input  logic [1:0]      mode_i,
    input  logic            ser_in_i,
    output logic [SIZE-1:0] d_next_o,
    output logic            ser_out_o
);

    always_comb begin
        d_next_o  = d_i;
        ser_out_o = d_i[SIZE-1];
        unique case (mode_i)
            MODE_SHL: begin
                d_next_o  = {d_i[SIZE-2:0], ser_in_i};
                ser_out_o = d_i[SIZE-1];
            end
            MODE_SHR: begin
                d_next_o  = {ser_in_i, d_i[SIZE-1:1]};
                ser_out_o = d_i[0];
            end
            MODE_ROL: begin
                d_next_o  = {d_i[SIZE-2:0], d_i[SIZE-1]};
                ser_out_o = d_i[SIZE-1];
            end
            MODE_ROR: begin
                d_next_o  = {d_i[0], d_i[SIZE-1:1]};
                ser_out_o = d_i[0];
            end
            default: begin
                d_next_o  = d_i;
                ser_out_o = d_i[SIZE-1];
            end
        endcase
    end

endmodule

// File: rtl/shiftreg_univ.sv
// Universal shift register with an autonomous burst engine.
//   clk_i, rst_ni  clock (rising edge), asynchronous active-low reset
//   load_i         parallel load of data_in_i; aborts any burst
//   en_i           one manual shift in mode_i (idle only)
//   mode_i         shift/rotate left/right
//   ser_in_i       serial input for the shift modes
//   start_i, len_i start a burst of len_i shifts (idle only)
//   data_in_i      parallel load data
//   data_out_o     register contents
//   ser_out_o      serial output in the active mode
//   busy_o         burst in progress
//   done_o         one-cycle pulse after the last burst shift
module shiftreg_univ
    import shiftreg_pkg::*;
#(
    parameter int unsigned SIZE = 8,
    parameter int unsigned CNTW = $clog2(SIZE) + 1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            load_i,
    input  logic            en_i,
    input  logic [1:0]      mode_i,
    input  logic            ser_in_i,
    input  logic            start_i,
    input  logic [CNTW-1:0] len_i,
    input  logic [SIZE-1:0] data_in_i,
    output logic [SIZE-1:0] data_out_o,
    output logic            ser_out_o,
    output logic            busy_o,
    output logic            done_o
);

    state_e          state_q;
    logic [CNTW-1:0] cnt_q;
    logic [1:0]      mode_q;
    logic [SIZE-1:0] data_q;

    logic [1:0]      mode_act;
    logic [SIZE-1:0] data_next;

    // During a burst the latched mode drives both the datapath and SerOut, so
    // mode_i may change freely while busy.
    assign mode_act = (state_q == ST_RUN) ? mode_q : mode_i;

    shiftreg_core #(
        .SIZE (SIZE)
    ) u_core (
        .d_i      (data_q),
        .mode_i   (mode_act),
        .ser_in_i (ser_in_i),
        .d_next_o (data_next),
        .ser_out_o(ser_out_o)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            mode_q  <= MODE_SHL;
            data_q  <= '0;
        end else if (load_i) begin
            // Load wins over everything and silently aborts a burst.
            data_q  <= data_in_i;
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        mode_q <= mode_i;
                        if (len_i != '0) begin
                            cnt_q   <= len_i;
                            state_q <= ST_RUN;
                        end else begin
                            state_q <= ST_DONE;
                        end
                    end else if (en_i) begin
                        data_q <= data_next;
                    end
                end
                ST_RUN: begin
                    data_q <= data_next;
                    cnt_q  <= cnt_q - CNTW'(1);
                    if (cnt_q == CNTW'(1)) begin
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign data_out_o = data_q;
    assign busy_o     = (state_q == ST_RUN);
    assign done_o     = (state_q == ST_DONE);

endmodule

// File: tb/tb_shiftreg_univ.sv
// Directed self-checking bench for shiftreg_univ (SIZE=8, CNTW=4).
module tb_shiftreg_univ;

    localparam int unsigned SIZE = 8;
    localparam int unsigned CNTW = 4;

    logic            clk;
    logic            rst_n;
    logic            load;
    logic            en;
    logic [1:0]      mode;
    logic            ser_in;
    logic            start;
    logic [CNTW-1:0] len;
    logic [SIZE-1:0] data_in;
    logic [SIZE-1:0] data_out;
    logic            ser_out;
    logic            busy;
    logic            done;

    int tests;
    int fails;

    shiftreg_univ #(
        .SIZE(SIZE),
        .CNTW(CNTW)
    ) dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .load_i    (load),
        .en_i      (en),
        .mode_i    (mode),
        .ser_in_i  (ser_in),
        .start_i   (start),
        .len_i     (len),
        .data_in_i (data_in),
        .data_out_o(data_out),
        .ser_out_o (ser_out),
        .busy_o    (busy),
        .done_o    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge and sample 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_load(input logic [SIZE-1:0] v);
        load    = 1'b1;
        data_in = v;
        step();
        load    = 1'b0;
    endtask

    logic [7:0] shr_seq;

    initial begin
        tests   = 0;
        fails   = 0;
        rst_n   = 1'b0;
        load    = 1'b0;
        en      = 1'b0;
        mode    = 2'b00;
        ser_in  = 1'b0;
        start   = 1'b0;
        len     = '0;
        data_in = '0;
        shr_seq = 8'b1010_0101; // bit i is the serial bit for shift i

        step();
        step();
        rst_n = 1'b1;
        step();
        check("reset_data", 32'(data_out), 32'h00);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);

        // Parallel load
        do_load(8'hA5);
        check("load_a5", 32'(data_out), 32'hA5);

        // Manual shifts
        do_load(8'h81);
        mode   = 2'b00;
        ser_in = 1'b1;
        en     = 1'b1;
        step();
        en = 1'b0;
        check("en_shl_data", 32'(data_out), 32'h03);
        check("en_shl_serout", 32'(ser_out), 32'd0);
        check("en_shl_nobusy", 32'(busy), 32'd0);
        mode = 2'b11;
        en   = 1'b1;
        step();
        en = 1'b0;
        check("en_ror_data", 32'(data_out), 32'h81);
        check("en_ror_serout", 32'(ser_out), 32'd1);

        // Burst rotate left, Len=3, mode_i toggled every cycle
        do_load(8'hB4);
        mode  = 2'b10;
        len   = 4'd3;
        start = 1'b1;
        step();
        start = 1'b0;
        mode  = 2'b11;
        check("rol_busy0", 32'(busy), 32'd1);
        check("rol_data0", 32'(data_out), 32'hB4);
        step();
        mode = 2'b00;
        check("rol_data1", 32'(data_out), 32'h69);
        check("rol_serout_latched", 32'(ser_out), 32'd0);
        // Start and En while busy must be ignored
        start = 1'b1;
        len   = 4'd1;
        en    = 1'b1;
        step();
        start = 1'b0;
        en    = 1'b0;
        mode  = 2'b01;
        check("rol_data2", 32'(data_out), 32'hD2);
        check("rol_busy2", 32'(busy), 32'd1);
        step();
        check("rol_data3", 32'(data_out), 32'hA5);
        check("rol_busy_end", 32'(busy), 32'd0);
        check("rol_done", 32'(done), 32'd1);
        // Start in the DONE cycle is dropped
        start = 1'b1;
        len   = 4'd2;
        step();
        start = 1'b0;
        check("done_pulse_end", 32'(done), 32'd0);
        check("start_in_done_busy", 32'(busy), 32'd0);
        step();
        check("start_in_done_busy2", 32'(busy), 32'd0);
        check("start_in_done_data", 32'(data_out), 32'hA5);

        // Burst shift right, Len=8, LSB-first serial stream
        do_load(8'hF0);
        mode  = 2'b01;
        len   = 4'd8;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check("shr_busy", 32'(busy), 32'd1);
            ser_in = shr_seq[i];
            step();
            if (i == 0) check("shr_first", 32'(data_out), 32'hF8);
        end
        check("shr_data", 32'(data_out), 32'hA5);
        check("shr_done", 32'(done), 32'd1);
        check("shr_busy_end", 32'(busy), 32'd0);

        // Len=0: immediate Done, no busy, no shift
        step();
        do_load(8'h5A);
        mode  = 2'b00;
        len   = 4'd0;
        start = 1'b1;
        step();
        start = 1'b0;
        check("len0_done", 32'(done), 32'd1);
        check("len0_busy", 32'(busy), 32'd0);
        check("len0_data", 32'(data_out), 32'h5A);
        step();
        check("len0_done_end", 32'(done), 32'd0);

        // Abort with Load at burst cycle 2 of Len=5
        len    = 4'd5;
        ser_in = 1'b0;
        start  = 1'b1;
        step();
        start = 1'b0;
        step();
        check("abort_data1", 32'(data_out), 32'hB4);
        load    = 1'b1;
        data_in = 8'h3C;
        step();
        load = 1'b0;
        check("abort_data", 32'(data_out), 32'h3C);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        step();
        check("abort_no_done", 32'(done), 32'd0);
        check("abort_hold", 32'(data_out), 32'h3C);

        // Asynchronous reset mid-burst
        len   = 4'd5;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        rst_n = 1'b0;
        #1;
        check("arst_data", 32'(data_out), 32'h00);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        step();
        rst_n = 1'b1;
        do_load(8'hA5);
        check("post_reset_load", 32'(data_out), 32'hA5);
        check("post_reset_idle", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/shiftreg_univ.md
# shiftreg_univ

Parametrised universal shift register: the successor to the single-direction serial/parallel register. It adds left/right shift and rotate modes, direction-aware serial output, and an autonomous burst engine that performs a programmed number of shifts under a Start/Busy/Done handshake. It sits between parallel-bus producers and serial links (SPI-style transmit/receive, bit-serial arithmetic), so the controller no longer counts shifts itself.

## Interface
- SIZE, 8: register width in bits (≥2).
- CNTW, $clog2(SIZE)+1: width of Len and the internal shift counter; maximum burst is 2^CNTW−1.

- Clk  in  1  clock, rising edge.
- Rst_n  in  1  asynchronous, active-low reset.
- Load  in  1  parallel load of DataIn; highest priority after reset.
- En  in  1  single manual shift in the current Mode; honoured only in IDLE.
- Mode  in  2  00 shift left, 01 shift right, 10 rotate left, 11 rotate right.
- SerIn  in  1  serial input bit for the shift modes; ignored in the rotate modes.
- Start  in  1  begins a burst of Len shifts; honoured only in IDLE.
- Len  in  CNTW  burst length; sampled together with Start.
- DataIn  in  SIZE  parallel load data.
- DataOut  out  SIZE  register contents.
- SerOut  out  1  DataOut[SIZE-1] for modes 00/10, DataOut[0] for modes 01/11 (the active mode: latched Mode in RUN, input Mode otherwise).
- Busy  out  1  high in RUN.
- Done  out  1  one-cycle pulse in DONE.

## Operation
- Shift left: {D[SIZE-2:0], SerIn}. Shift right: {SerIn, D[SIZE-1:1]}. Rotate left: {D[SIZE-2:0], D[SIZE-1]}. Rotate right: {D[0], D[SIZE-1:1]}.
- FSM states IDLE, RUN, DONE; reset state IDLE.
- IDLE: Load → DataOut=DataIn. Else Start → latch Mode and Len; go to RUN with count=Len when Len≠0, or directly to DONE when Len=0; no shift on the Start edge. Else En → one shift. Else hold.
- RUN: each edge shifts using the latched mode and live SerIn, and decrements count. The shift that takes count from 1 to 0 is the last one, and the FSM moves to DONE on that edge. Mode and Len input changes are ignored.
- DONE: lasts exactly one cycle, then IDLE. No shift. Start and En are ignored in this cycle.
- Load in RUN or DONE aborts: DataOut=DataIn, FSM goes to IDLE, count cleared, no Done pulse.
- Start or En while Busy: ignored, with no queuing. Load+Start together in IDLE: the load wins and Start is dropped.
- Reset asserted at any time, including mid-burst: DataOut=0, FSM=IDLE, count=0, Busy=0, Done=0, and the latched mode is 00.

## Timing
- Every state and data update is registered. SerOut is combinational from DataOut and the active mode. Busy and Done decode the state directly.
- Burst of L≥1 starting with Start at edge t0: shifts at edges t1..tL. Busy is high from after t0 until after tL. Done is high for the single cycle after tL.
- Len=0: Done is high for the single cycle after t0, Busy never rises, and DataOut is unchanged.
- Back-to-back bursts: the earliest accepted Start is at the edge ending the first IDLE cycle after DONE, so the minimum burst period is L+2 cycles.
- Manual En shift: one edge, with no handshake outputs.

## Structure
- Package shiftreg_pkg holds:
  - the mode encodings MODE_SHL, MODE_SHR, MODE_ROL, MODE_ROR;
  - the state enum ST_IDLE, ST_RUN, ST_DONE (2-bit).
- Sub-module shiftreg_core: a combinational next-value and SerOut mux parameterised by SIZE, taking D, Mode and SerIn. The top level contains the FSM, counter, mode latch and DataOut register.

## Test plan
- Reset and load: assert Rst_n=0 mid-burst → DataOut=0x00, Busy=0, Done=0 immediately. Then Load with DataIn=0xA5 → DataOut=0xA5.
- Manual shifts: DataOut=0x81, Mode=00, SerIn=1, one En → 0x03 and SerOut=0. Mode=11, one En → 0x81 and SerOut=1.
- Burst rotate: DataOut=0xB4, Start with Len=3 and Mode=10, while toggling Mode every cycle → Busy high for 3 cycles, DataOut=0xA5, Done pulse 1 cycle.
- Burst shift right: DataOut=0xF0, Len=8, Mode=01, SerIn sequence 1,0,1,0,0,1,0,1 (LSB first) → DataOut=0xA5 after 8 shifts, Done at cycle 9.
- Boundaries:
  - Start with Len=0 → Done in the next cycle, Busy=0, DataOut unchanged.
  - Start and En pulsed during Busy → no effect.
  - Start in the DONE cycle → ignored.
- Abort: Load with DataIn=0x3C at burst cycle 2 of a Len=5 burst → DataOut=0x3C, IDLE next cycle, no Done pulse.
